// File: rtl/io_port_sched.sv
// io_port_sched: channel I/O scheduler between external sample streams and
// the network processor's integer I/O ports. Each input channel holds one
// sample that is handed out on a one-hot read strobe. Each output channel
// captures a processor result on a one-hot write strobe and hands it to a
// downstream consumer with a valid/ready handshake. Underrun, overrun and
// strobe-protocol errors are kept as sticky status bits.
module io_port_sched #(
    parameter int NBIN   = 19,
    parameter int NBOUT  = 28,
    parameter int NUIOIN = 4,
    parameter int NUIOOU = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUIOIN*NBIN-1:0]   src_data,
    input  logic [NUIOIN-1:0]        src_valid,
    output logic [NUIOIN-1:0]        src_ready,
    input  logic [NUIOIN-1:0]        req_in,
    output logic [NBIN-1:0]          io_in,
    input  logic [NUIOOU-1:0]        out_en,
    input  logic [NBOUT-1:0]         io_out,
    output logic [NUIOOU*NBOUT-1:0]  dst_data,
    output logic [NUIOOU-1:0]        dst_valid,
    input  logic [NUIOOU-1:0]        dst_ready,
    input  logic                     clr_flags,
    output logic [NUIOIN-1:0]        underrun,
    output logic [NUIOOU-1:0]        overrun,
    output logic                     proto_err
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } in_state_e;

    // Keep only the lowest set bit of a read strobe.
    function automatic logic [NUIOIN-1:0] lowest_in(input logic [NUIOIN-1:0] v);
        logic [NUIOIN-1:0] r;
        r = '0;
        for (int i = NUIOIN - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Keep only the lowest set bit of a write strobe.
    function automatic logic [NUIOOU-1:0] lowest_ou(input logic [NUIOOU-1:0] v);
        logic [NUIOOU-1:0] r;
        r = '0;
        for (int i = NUIOOU - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                     rdy_en_q;
    in_state_e                in_state_q [NUIOIN];
    logic [NBIN-1:0]          sample_q   [NUIOIN];

    logic [NUIOOU*NBOUT-1:0]  dst_data_q, dst_data_d;
    logic [NUIOOU-1:0]        dst_valid_q, dst_valid_d;
    logic [NUIOIN-1:0]        underrun_q, underrun_d;
    logic [NUIOOU-1:0]        overrun_q, overrun_d;
    logic                     proto_err_q, proto_err_d;

    logic [NUIOIN-1:0]        rd_sel;
    logic [NUIOOU-1:0]        wr_sel;
    logic [NUIOIN-1:0]        full;
    logic                     multi_hot;

    assign rd_sel    = lowest_in(req_in);
    assign wr_sel    = lowest_ou(out_en);
    assign multi_hot = (req_in != rd_sel) || (out_en != wr_sel);

    // Per-channel full view of the input FSMs.
    always_comb begin
        for (int k = 0; k < NUIOIN; k++) begin
            full[k] = (in_state_q[k] == ST_FULL);
        end
    end

    // Ready comes only from registered state; the enable flop holds it low
    // through reset and for the first edge after release.
    assign src_ready = full ^ {NUIOIN{1'b1}} & {NUIOIN{rdy_en_q}};

    // Ready-enable: rises on the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    // Input channel FSMs: EMPTY loads on a handshake, FULL drains on a read.
    // NOTE: the sample registers are cleared on reset as well as the state,
    // because the buffers are architecturally visible as reset-to-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUIOIN; k++) begin
                in_state_q[k] <= ST_EMPTY;
                sample_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                case (in_state_q[k])
                    ST_EMPTY: begin
                        // A read of an empty channel never consumes a
                        // sample arriving in the same cycle.
                        if (src_valid[k] && rdy_en_q) begin
                            sample_q[k]   <= src_data[k*NBIN +: NBIN];
                            in_state_q[k] <= ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        if (rd_sel[k]) begin
                            in_state_q[k] <= ST_EMPTY;
                        end
                    end
                    default: in_state_q[k] <= ST_EMPTY;
                endcase
            end
        end
    end

    // Zero-latency read path: selected buffer if full, otherwise zero.
    // NOTE: every combinational output gets a default before the loop so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        io_in = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (rd_sel[k] && full[k]) begin
                io_in = sample_q[k];
            end
        end
    end

    // Output channels: write has priority over drain; overrun when a
    // pending result is replaced without having been accepted.
    always_comb begin
        dst_data_d  = dst_data_q;
        dst_valid_d = dst_valid_q;
        overrun_d   = clr_flags ? '0 : overrun_q;
        for (int j = 0; j < NUIOOU; j++) begin
            if (wr_sel[j]) begin
                dst_data_d[j*NBOUT +: NBOUT] = io_out;
                dst_valid_d[j]               = 1'b1;
                if (dst_valid_q[j] && !dst_ready[j]) begin
                    overrun_d[j] = 1'b1;
                end
            end else if (dst_ready[j]) begin
                dst_valid_d[j] = 1'b0;
            end
        end
    end

    // Sticky input/protocol flags; a fresh error outranks a clear.
    always_comb begin
        underrun_d  = (clr_flags ? '0 : underrun_q) | (rd_sel & ~full);
        proto_err_d = (proto_err_q && !clr_flags) || multi_hot;
    end

    // Output-side and status registers.
    // NOTE: sequential state is updated only with non-blocking assignments;
    // next-state values are computed in the always_comb blocks above.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dst_data_q  <= '0;
            dst_valid_q <= '0;
            underrun_q  <= '0;
            overrun_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            dst_data_q  <= dst_data_d;
            dst_valid_q <= dst_valid_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign dst_data  = dst_data_q;
    assign dst_valid = dst_valid_q;
    assign underrun  = underrun_q;
    assign overrun   = overrun_q;
    assign proto_err = proto_err_q;

endmodule

// File: doc/io_port_sched.md
Name: io_port_sched

Overview:
- Channel I/O scheduler between external sample streams and the floating-point network processor's I/O ports.
- Buffers one sample per input channel and presents it on the processor's integer input when the decoded one-hot read strobe selects that channel.
- Captures processor results into per-output-channel registers on the decoded one-hot write enable, then drains them to downstream consumers with valid/ready handshakes.
- Flags underrun, overrun and strobe-protocol errors as sticky status bits.

Parameters:
- NBIN, 19: input sample width (signed integer, pre int-to-float conversion)
- NBOUT, 28: output result width (signed integer, post float-to-int conversion)
- NUIOIN, 4: number of input channels
- NUIOOU, 4: number of output channels

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- src_data  in  NUIOIN*NBIN  packed samples, channel k at [k*NBIN +: NBIN]
- src_valid  in  NUIOIN  per-channel sample valid
- src_ready  out  NUIOIN  per-channel buffer can accept
- req_in  in  NUIOIN  one-hot processor read strobe
- io_in  out  NBIN  signed sample to processor
- out_en  in  NUIOOU  one-hot processor write strobe
- io_out  in  NBOUT  signed result from processor
- dst_data  out  NUIOOU*NBOUT  packed results, channel j at [j*NBOUT +: NBOUT]
- dst_valid  out  NUIOOU  per-channel result valid
- dst_ready  in  NUIOOU  per-channel consumer accept
- clr_flags  in  1  synchronous clear of all sticky flags
- underrun  out  NUIOIN  sticky: read of empty input buffer
- overrun  out  NUIOOU  sticky: unconsumed result overwritten
- proto_err  out  1  sticky: multi-hot req_in or out_en

Behaviour:
- Reset (rst=0, async):
  - All input buffers, full flags, dst_data, dst_valid and flags go to 0.
  - src_ready is forced 0 while rst=0.
- Input channel k (state EMPTY/FULL):
  - src_ready[k] = ~full[k], registered-state only, with no combinational path from src_valid or req_in.
  - Load when src_valid[k] & src_ready[k]: buf[k] <= sample, full[k] <= 1 (EMPTY->FULL).
- Read:
  - io_in is combinational: buf[s] if full[s], else 0, where s is the lowest set bit of req_in. io_in is 0 when req_in is 0.
  - At the edge, the selected channel with full[s]=1 clears full[s] (FULL->EMPTY). Zero-latency read; the processor samples io_in in the strobe cycle.
  - Read of an EMPTY channel: io_in=0 and underrun[s] <= 1. A sample loading that same cycle is stored and not consumed.
- Output channel j:
  - On out_en[j] (lowest set bit if multi-hot): dst_data[j] <= io_out and dst_valid[j] <= 1, one-cycle latency.
  - Drain: dst_valid[j] & dst_ready[j] with no write to j clears dst_valid[j]. dst_data holds its last value.
  - Write while dst_valid[j]=1 and dst_ready[j]=0: data overwritten, valid stays 1, overrun[j] <= 1.
  - Write in the same cycle as a handshake on j: new data is stored, valid stays 1, no overrun.
- Multi-hot req_in or out_en: only the lowest index is serviced, and proto_err <= 1.
- clr_flags clears underrun, overrun and proto_err. A new error in the same cycle takes priority: the bit stays set.
- Input and output sides are fully independent; simultaneous read and write in one cycle are both serviced.
- Widths pass through unchanged; no arithmetic on data.

Test Plan:
- Reset release, src_valid[2]=1 with data 19'h12345, then req_in=4'b0100 two cycles later:
  - src_ready[2] drops one cycle after the load.
  - io_in=19'h12345 during the strobe.
  - src_ready[2]=1 the next cycle; underrun=0.
- req_in=4'b0001 with channel 0 empty while src_valid[0] loads -7:
  - io_in=0 and underrun[0]=1.
  - Next req_in=4'b0001 yields io_in=-7.
- out_en=4'b1000, io_out=28'h0ABCDEF with dst_ready[3]=0, then out_en=4'b1000 with io_out=5:
  - dst_data[3]=5, dst_valid[3]=1, overrun[3]=1.
  - With dst_ready[3]=1 and no write, dst_valid[3] -> 0.
- out_en[1] pulse coinciding with a dst_ready[1] handshake: new value stored, dst_valid[1] stays 1, overrun[1]=0.
- req_in=4'b0110 with channels 1 and 2 full: io_in=buf[1], only channel 1 empties, proto_err=1.
  - clr_flags pulse clears proto_err.
  - clr_flags coinciding with a fresh underrun leaves underrun set.
- Assert rst mid-transfer with channels full and dst_valid=1: all outputs go to 0 immediately, asynchronously.
  - src_ready returns to all ones one cycle-edge after release.
